// File: rtl/fft_frame_tx.sv
// Purpose: buffers a free-running complex sample stream and emits gap-free sop/eop frames into an FFT sink.
// Latency: FIFO level reaching N in cycle t raises src_valid/src_sop in cycle t+1.
// Backpressure: src_ready stalls the output register; the input side has none, so samples arriving while full are dropped and flagged.
module fft_frame_tx #(
  parameter int DW      = 14,
  parameter int PTS_W   = 11,
  parameter int FIFO_AW = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_real,
  input  logic [DW-1:0]      in_imag,
  input  logic [PTS_W-1:0]   cfg_fftpts,
  input  logic               cfg_inverse,
  input  logic               ovf_clr,
  output logic               src_valid,
  input  logic               src_ready,
  output logic               src_sop,
  output logic               src_eop,
  output logic [1:0]         src_error,
  output logic [DW-1:0]      src_real,
  output logic [DW-1:0]      src_imag,
  output logic [PTS_W-1:0]   src_fftpts,
  output logic               src_inverse,
  output logic               cfg_err,
  output logic               ovf_sticky,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        frame_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  // Sample storage: real in the upper half, imag in the lower half.
  logic [2*DW-1:0]    mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;

  logic [0:0]         state_q, state_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic [PTS_W-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0]    dat_q, dat_d;
  logic [PTS_W-1:0]   pts_q, pts_d;
  logic               inv_q, inv_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               ovf_q, ovf_d;

  logic full, wr_en, drop, pop, accept, n_legal, level_ok;

  assign full   = (level_q == DEPTH);
  assign wr_en  = in_valid & ~full;
  assign drop   = in_valid & full;
  assign accept = valid_q & src_ready;

  // Legal frame lengths are the powers of two from 8 to 1024.
  assign n_legal  = (cfg_fftpts >= PTS_W'(8)) && (cfg_fftpts <= PTS_W'(1024)) &&
                    ((cfg_fftpts & (cfg_fftpts - PTS_W'(1))) == '0);
  assign level_ok = (level_q >= (FIFO_AW+1)'(cfg_fftpts));

  // Frame sequencing: start only with a whole frame buffered, so the frame never runs dry.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    pts_d   = pts_q;
    inv_d   = inv_q;
    fcnt_d  = fcnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (n_legal && level_ok) begin
          pop     = 1'b1;
          dat_d   = mem[rd_ptr_q];
          pts_d   = cfg_fftpts;
          inv_d   = cfg_inverse;
          cnt_d   = cfg_fftpts - PTS_W'(1);
          valid_d = 1'b1;
          sop_d   = 1'b1;
          state_d = ST_STREAM;
        end
      end
      default: begin
        if (accept) begin
          if (cnt_q == '0) begin
            // Last beat taken: drop valid for at least one cycle between frames.
            valid_d = 1'b0;
            sop_d   = 1'b0;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            pop   = 1'b1;
            dat_d = mem[rd_ptr_q];
            cnt_d = cnt_q - PTS_W'(1);
            sop_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Occupancy and overflow flag; a drop in the same cycle beats ovf_clr.
  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Sample memory write port (no reset; contents are only read behind the level count).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {in_real, in_imag};
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      cnt_q    <= '0;
      dat_q    <= '0;
      pts_q    <= '0;
      inv_q    <= 1'b0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      pts_q   <= pts_d;
      inv_q   <= inv_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // eop derives from registered state only, so it is stable across a stall.
  assign src_valid   = valid_q;
  assign src_sop     = sop_q;
  assign src_eop     = valid_q & (cnt_q == '0);
  assign src_error   = 2'b00;
  assign src_real    = dat_q[2*DW-1:DW];
  assign src_imag    = dat_q[DW-1:0];
  assign src_fftpts  = pts_q;
  assign src_inverse = inv_q;
  assign cfg_err     = (state_q == ST_IDLE) & ~n_legal;
  assign ovf_sticky  = ovf_q;
  assign fifo_level  = level_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
module tb_fft_frame_tx;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_real, in_imag;
  logic [10:0]   cfg_fftpts;
  logic          cfg_inverse;
  logic          ovf_clr;
  logic          src_valid, src_ready, src_sop, src_eop;
  logic [1:0]    src_error;
  logic [DW-1:0] src_real, src_imag;
  logic [10:0]   src_fftpts;
  logic          src_inverse, cfg_err, ovf_sticky;
  logic [11:0]   fifo_level;
  logic [15:0]   frame_cnt;

  fft_frame_tx dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .cfg_fftpts(cfg_fftpts), .cfg_inverse(cfg_inverse), .ovf_clr(ovf_clr),
    .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
    .src_error(src_error), .src_real(src_real), .src_imag(src_imag), .src_fftpts(src_fftpts),
    .src_inverse(src_inverse), .cfg_err(cfg_err), .ovf_sticky(ovf_sticky),
    .fifo_level(fifo_level), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected samples in write order, expected frames as {inverse, N}.
  logic [2*DW-1:0] exp_q [$];
  logic [11:0]     fr_q  [$];
  int              mon_idx = 0;
  logic            stall = 1'b0;
  logic [41:0]     snap;
  logic [15:0]     seq = 16'd1;

  // Monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [11:0]     cur;
    logic [2*DW-1:0] e;
    if (reset_n) begin
      if (stall) begin
        chk("hold_valid", src_valid, 1);
        chk("hold_outputs", {src_real, src_imag, src_sop, src_eop, src_fftpts, src_inverse}, snap);
      end
      if (mon_idx != 0) chk("no_gap", src_valid, 1);
      if (src_valid && src_ready) begin
        if (fr_q.size() == 0) begin
          chk("unexpected_beat", fr_q.size(), 0);
        end else begin
          cur = fr_q[0];
          chk("sop", src_sop, (mon_idx == 0));
          chk("eop", src_eop, (mon_idx == int'(cur[10:0]) - 1));
          chk("fftpts", src_fftpts, cur[10:0]);
          chk("inverse", src_inverse, cur[11]);
          chk("error", src_error, 0);
          if (exp_q.size() == 0) begin
            chk("sample_avail", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("data", {src_real, src_imag}, e);
          end
          mon_idx++;
          if (mon_idx == int'(cur[10:0])) begin
            mon_idx = 0;
            void'(fr_q.pop_front());
          end
        end
      end
      stall = src_valid && !src_ready;
      snap  = {src_real, src_imag, src_sop, src_eop, src_fftpts, src_inverse};
    end else begin
      stall = 1'b0;
    end
  end

  task automatic put_sample(input bit do_push);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_real  = seq[DW-1:0];
    in_imag  = ~seq[DW-1:0];
    if (do_push) exp_q.push_back({in_real, in_imag});
    seq++;
  endtask

  task automatic stop_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic put_n(input int n);
    for (int i = 0; i < n; i++) put_sample(1'b1);
    stop_in();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (fr_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, fr_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_sop(input string tag, input int budget);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (src_valid && src_sop) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    cfg_fftpts = 11'd8; cfg_inverse = 1'b0; ovf_clr = 1'b0; src_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", src_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_fftpts", src_fftpts, 0);
    chk("rst_ovf", ovf_sticky, 0);

    // 1: N=8 single frame, first-beat latency.
    fr_q.push_back({1'b0, 11'd8});
    put_n(8);
    @(negedge clk);
    chk("t1_level8", fifo_level, 8);
    chk("t1_not_yet", src_valid, 0);
    @(negedge clk);
    chk("t1_first_valid", src_valid, 1);
    chk("t1_first_sop", src_sop, 1);
    wait_done("t1_done", 50);
    chk("t1_fcnt", frame_cnt, 1);
    chk("t1_level0", fifo_level, 0);

    // 2: N=16 with ready toggling.
    cfg_fftpts = 11'd16;
    src_ready  = 1'b0;
    fr_q.push_back({1'b0, 11'd16});
    put_n(16);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      src_ready = ~src_ready;
    end
    src_ready = 1'b1;
    wait_done("t2_done", 100);
    chk("t2_fcnt", frame_cnt, 2);

    // 3: overflow with no frame allowed to start.
    cfg_fftpts = 11'd0;
    src_ready  = 1'b0;
    for (int i = 0; i < 2048; i++) put_sample(1'b1);
    put_sample(1'b0);
    stop_in();
    @(negedge clk);
    chk("t3_level_full", fifo_level, 2048);
    chk("t3_ovf_set", ovf_sticky, 1);
    chk("t3_cfg_err", cfg_err, 1);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", ovf_sticky, 0);
    fr_q.push_back({1'b0, 11'd1024});
    fr_q.push_back({1'b0, 11'd1024});
    cfg_fftpts = 11'd1024;
    src_ready  = 1'b1;
    wait_done("t3_done", 5000);
    chk("t3_fcnt", frame_cnt, 4);
    chk("t3_level0", fifo_level, 0);
    chk("t3_no_extra", exp_q.size(), 0);

    // 4: illegal N blocks the frame; switching to 32 starts it.
    cfg_fftpts = 11'd12;
    put_n(32);
    repeat (3) @(negedge clk);
    chk("t4_cfg_err", cfg_err, 1);
    chk("t4_level", fifo_level, 32);
    chk("t4_no_frame", src_valid, 0);
    fr_q.push_back({1'b0, 11'd32});
    @(posedge clk); #1; cfg_fftpts = 11'd32;
    @(negedge clk);
    chk("t4_cfg_ok", cfg_err, 0);
    @(negedge clk);
    chk("t4_start", src_valid, 1);
    wait_done("t4_done", 100);
    chk("t4_fcnt", frame_cnt, 5);

    // 5: config change mid-frame only affects the next frame.
    cfg_fftpts = 11'd8;
    cfg_inverse = 1'b0;
    fr_q.push_back({1'b0, 11'd8});
    fr_q.push_back({1'b1, 11'd16});
    put_n(8);
    wait_sop("t5_sop", 20);
    repeat (3) @(posedge clk);
    #1;
    cfg_fftpts  = 11'd16;
    cfg_inverse = 1'b1;
    put_n(16);
    wait_done("t5_done", 100);
    chk("t5_fcnt", frame_cnt, 7);

    // 6: reset in the middle of an N=64 frame.
    cfg_fftpts  = 11'd64;
    cfg_inverse = 1'b0;
    fr_q.push_back({1'b0, 11'd64});
    put_n(64);
    wait_sop("t6_sop", 20);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    fr_q.delete();
    mon_idx = 0;
    #1;
    chk("t6_rst_outs", {src_valid, src_sop, src_eop, src_real, src_imag, src_fftpts, src_inverse, ovf_sticky}, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_fcnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cfg_fftpts = 11'd8;
    fr_q.push_back({1'b0, 11'd8});
    put_n(8);
    wait_done("t6_done", 50);
    chk("t6_fcnt", frame_cnt, 1);
    chk("t6_level0", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
